// File: rtl/in_fifo_drain.sv
// IN_FIFO read-side drain: RDEN issue, Q capture after RD_LAT cycles, 2-entry skid buffer onto valid/ready (first word RD_LAT+1 cycles after RDEN).
// Reads are credit-limited so a stalled M_READY never overflows the buffer; FLUSH drains and discards; IN_FIFO_DRAIN_CNT_EN builds WORD_CNT.
module in_fifo_drain #(
  parameter int NUM_CH = 10,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic                 RDCLK,
  input  logic                 RESET_N,
  input  logic                 EMPTY,
  input  logic                 ALMOSTEMPTY,
  input  logic [NUM_CH*DW-1:0] Q,
  output logic                 RDEN,
  input  logic                 FLUSH,
  output logic [NUM_CH*DW-1:0] M_DATA,
  output logic                 M_VALID,
  input  logic                 M_READY,
  output logic                 BUSY,
  output logic                 ERR,
  output logic [31:0]          WORD_CNT
);

  localparam int W = NUM_CH * DW;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t            state_q, state_d;
  logic [RD_LAT-1:0] rd_sr_q, rd_sr_d;
  logic [1:0]        occ_q, occ_d;
  logic [W-1:0]      ent0_q, ent0_d, ent1_q, ent1_d;
  logic              err_q, err_d;
  logic [1:0]        inflight;
  logic [2:0]        used;
  logic              cap, pop, flushing, accept;
  logic              unused_almostempty;

  assign unused_almostempty = ALMOSTEMPTY;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + {1'b0, rd_sr_q[i]};
  end

  assign pop      = (occ_q != 2'd0) && M_READY;
  assign cap      = rd_sr_q[RD_LAT-1];
  assign flushing = (state_q == S_FLUSH) || FLUSH;
  assign accept   = cap && (state_q == S_RUN) && !FLUSH;
  // A head popping this cycle frees its slot in time for a read issued now.
  assign used     = {1'b0, occ_q} + {1'b0, inflight} - {2'b00, pop};

  always_comb begin
    RDEN = 1'b0;
    unique case (state_q)
      S_RUN:   RDEN = !EMPTY && (used < 3'd2);
      S_FLUSH: RDEN = !EMPTY;
      default: RDEN = 1'b0;
    endcase
  end

  always_comb begin
    rd_sr_d    = '0;
    rd_sr_d[0] = RDEN;
    for (int i = 1; i < RD_LAT; i++) rd_sr_d[i] = rd_sr_q[i-1];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (FLUSH)       state_d = S_FLUSH;
        else if (!EMPTY) state_d = S_RUN;
      end
      S_RUN: begin
        if (FLUSH) state_d = S_FLUSH;
        else if (EMPTY && inflight == 2'd0 && occ_q == 2'd0) state_d = S_IDLE;
      end
      S_FLUSH: begin
        if (!FLUSH && inflight == 2'd0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    occ_d  = occ_q;
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    if (flushing) begin
      occ_d = 2'd0;
    end else begin
      if (pop) begin
        ent0_d = ent1_q;
        occ_d  = occ_q - 2'd1;
      end
      // Overflow (full, no pop) drops the word and is reported through ERR.
      if (accept) begin
        if (occ_d == 2'd0) begin
          ent0_d = Q;
          occ_d  = 2'd1;
        end else if (occ_d == 2'd1) begin
          ent1_d = Q;
          occ_d  = 2'd2;
        end
      end
    end
  end

  assign err_d = err_q || (accept && occ_q == 2'd2 && !pop) || (RDEN && EMPTY);

  always_ff @(posedge RDCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      rd_sr_q <= '0;
      occ_q   <= 2'd0;
      ent0_q  <= '0;
      ent1_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_sr_q <= rd_sr_d;
      occ_q   <= occ_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      err_q   <= err_d;
    end
  end

  assign M_DATA  = ent0_q;
  assign M_VALID = (occ_q != 2'd0);
  assign BUSY    = (inflight != 2'd0) || (occ_q != 2'd0) || (state_q == S_FLUSH);
  assign ERR     = err_q;

`ifdef IN_FIFO_DRAIN_CNT_EN
  logic [31:0] word_cnt_q, word_cnt_d;

  assign word_cnt_d = word_cnt_q + {31'd0, pop};

  always_ff @(posedge RDCLK or negedge RESET_N) begin
    if (!RESET_N) word_cnt_q <= '0;
    else          word_cnt_q <= word_cnt_d;
  end

  assign WORD_CNT = word_cnt_q;
`else
  assign WORD_CNT = '0;
`endif

endmodule

// File: tb/tb_in_fifo_drain.sv
// Directed bench for in_fifo_drain: behavioural IN_FIFO model on the read side, hand-computed cycle expectations.
module tb_in_fifo_drain;

`ifdef IN_FIFO_DRAIN_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        RDCLK = 1'b0;
  logic        RESET_N;
  logic        EMPTY;
  logic        ALMOSTEMPTY;
  logic [79:0] Q;
  logic        RDEN;
  logic        FLUSH;
  logic [79:0] M_DATA;
  logic        M_VALID;
  logic        M_READY;
  logic        BUSY;
  logic        ERR;
  logic [31:0] WORD_CNT;

  int n_run  = 0;
  int n_fail = 0;

  logic [79:0] mem [0:63];
  int wr_idx = 0;
  int rd_idx = 0;

  int exp_r [7] = '{1, 1, 1, 1, 0, 0, 0};
  int exp_v [7] = '{0, 0, 1, 1, 1, 1, 0};
  int exp_d [7] = '{0, 0, 1, 2, 3, 4, 0};

  in_fifo_drain #(.NUM_CH(10), .DW(8), .RD_LAT(1)) dut (
    .RDCLK       (RDCLK),
    .RESET_N     (RESET_N),
    .EMPTY       (EMPTY),
    .ALMOSTEMPTY (ALMOSTEMPTY),
    .Q           (Q),
    .RDEN        (RDEN),
    .FLUSH       (FLUSH),
    .M_DATA      (M_DATA),
    .M_VALID     (M_VALID),
    .M_READY     (M_READY),
    .BUSY        (BUSY),
    .ERR         (ERR),
    .WORD_CNT    (WORD_CNT)
  );

  always #5 RDCLK = ~RDCLK;

  // FIFO model: Q registered one cycle after RDEN, EMPTY follows the read pointer.
  assign EMPTY       = (rd_idx == wr_idx);
  assign ALMOSTEMPTY = 1'b0;

  always @(posedge RDCLK) begin
    if (RDEN && rd_idx != wr_idx) begin
      Q      <= mem[rd_idx];
      rd_idx <= rd_idx + 1;
    end
  end

  function automatic logic [79:0] word(input int b);
    logic [7:0] x;
    x = b[7:0];
    return {10{x}};
  endfunction

  task automatic chk(input string tag, input logic [79:0] act, input logic [79:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push(input int b);
    mem[wr_idx] = word(b);
    wr_idx++;
  endtask

  task automatic step();
    @(posedge RDCLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n_rd;
    int got;
    int xfers;
    xfers   = 0;
    RESET_N = 1'b0;
    FLUSH   = 1'b0;
    M_READY = 1'b0;
    Q       = '0;
    #12;
    chk("rst_rden",  80'(RDEN), 80'(0));
    chk("rst_valid", 80'(M_VALID), 80'(0));
    chk("rst_busy",  80'(BUSY), 80'(0));
    chk("rst_err",   80'(ERR), 80'(0));
    chk("rst_data",  M_DATA, 80'(0));
    chk("rst_cnt",   80'(WORD_CNT), 80'(0));
    @(negedge RDCLK);
    RESET_N = 1'b1;
    step();

    // Streaming: 4 words, ready held high.
    M_READY = 1'b1;
    for (int b = 1; b <= 4; b++) push(b);
    chk("stream_idle_rden", 80'(RDEN), 80'(0));
    for (int c = 0; c < 7; c++) begin
      step();
      chk("stream_rden", 80'(RDEN), 80'(exp_r[c]));
      chk("stream_vld", 80'(M_VALID), 80'(exp_v[c]));
      if (exp_v[c] != 0) chk("stream_data", M_DATA, word(exp_d[c]));
    end
    xfers += 4;
    step();
    chk("stream_cnt", 80'(WORD_CNT), 80'(CNT_EN ? xfers : 0));

    // Backpressure: 5 words, ready low -> only two reads.
    M_READY = 1'b0;
    for (int b = 8'h11; b <= 8'h15; b++) push(b);
    n_rd = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (RDEN) n_rd++;
    end
    chk("bp_rden_pulses", 80'(n_rd), 80'(2));
    chk("bp_vld", 80'(M_VALID), 80'(1));
    chk("bp_head", M_DATA, word(8'h11));
    step(); step(); step();
    chk("bp_head_stable", M_DATA, word(8'h11));
    M_READY = 1'b1;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      if (M_VALID) begin
        chk("bp_data", M_DATA, word(8'h11 + got));
        got++;
      end
      step();
    end
    chk("bp_count", 80'(got), 80'(5));
    chk("bp_err", 80'(ERR), 80'(0));
    xfers += 5;
    chk("bp_cnt", 80'(WORD_CNT), 80'(CNT_EN ? xfers : 0));

    // Flush: one word buffered, three left in the FIFO.
    M_READY = 1'b0;
    push(8'h21);
    step(); step(); step();
    chk("fl_pre_vld", 80'(M_VALID), 80'(1));
    chk("fl_pre_data", M_DATA, word(8'h21));
    FLUSH = 1'b1;
    for (int b = 8'h22; b <= 8'h24; b++) push(b);
    step();
    chk("fl_vld_drop", 80'(M_VALID), 80'(0));
    chk("fl_rden", 80'(RDEN), 80'(1));
    chk("fl_busy", 80'(BUSY), 80'(1));
    for (int c = 0; c < 5; c++) begin
      step();
      chk("fl_vld_low", 80'(M_VALID), 80'(0));
    end
    chk("fl_drained", 80'(EMPTY), 80'(1));
    chk("fl_busy_hold", 80'(BUSY), 80'(1));
    FLUSH = 1'b0;
    step();
    chk("fl_idle_busy", 80'(BUSY), 80'(0));
    chk("fl_idle_rden", 80'(RDEN), 80'(0));
    chk("fl_err", 80'(ERR), 80'(0));
    chk("fl_cnt", 80'(WORD_CNT), 80'(CNT_EN ? xfers : 0));

    // Error: buffer full, then a capture is injected.
    push(8'h31);
    push(8'h32);
    for (int c = 0; c < 5; c++) step();
    chk("err_full_vld", 80'(M_VALID), 80'(1));
    chk("err_full_head", M_DATA, word(8'h31));
    chk("err_pre", 80'(ERR), 80'(0));
    force dut.rd_sr_q = 1'b1;
    step();
    release dut.rd_sr_q;
    step();
    chk("err_set", 80'(ERR), 80'(1));
    step(); step(); step();
    chk("err_sticky", 80'(ERR), 80'(1));
    chk("err_head_kept", M_DATA, word(8'h31));

    // Asynchronous reset with the buffer full.
    RESET_N = 1'b0;
    #1;
    chk("arst_vld",  80'(M_VALID), 80'(0));
    chk("arst_data", M_DATA, 80'(0));
    chk("arst_err",  80'(ERR), 80'(0));
    chk("arst_busy", 80'(BUSY), 80'(0));
    chk("arst_rden", 80'(RDEN), 80'(0));
    chk("arst_cnt",  80'(WORD_CNT), 80'(0));
    @(negedge RDCLK);
    RESET_N = 1'b1;
    xfers = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("post_rst_vld", 80'(M_VALID), 80'(0));
    end
    M_READY = 1'b1;
    push(8'h41);
    got = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (M_VALID) begin
        chk("post_rst_data", M_DATA, word(8'h41));
        got++;
      end
    end
    chk("post_rst_count", 80'(got), 80'(1));
    xfers += 1;
    chk("post_rst_cnt", 80'(WORD_CNT), 80'(CNT_EN ? xfers : 0));

    // Counter wrap from 0xFFFFFFFE over three transfers.
`ifdef IN_FIFO_DRAIN_CNT_EN
    force dut.word_cnt_q = 32'hFFFF_FFFE;
    step();
    release dut.word_cnt_q;
`endif
    for (int b = 8'h51; b <= 8'h53; b++) push(b);
    got = 0;
    for (int c = 0; c < 15; c++) begin
      step();
      if (M_VALID) begin
        chk("wrap_data", M_DATA, word(8'h51 + got));
        got++;
      end
    end
    chk("wrap_count", 80'(got), 80'(3));
    chk("wrap_cnt", 80'(WORD_CNT), 80'(CNT_EN ? 1 : 0));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
